// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the PC datapath: raw inputs in,
// debounced level plus press/release pulses out.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_conditioner.sv
// Two-flop synchronizer, per-channel debounce counter and press/release pulses.
// Defining BTN_REPEAT_EN adds auto-repeat press pulses while a button is held.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int REPEAT_DELAY    = 62500000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic                sysclk,
    input  logic                rst,
    button_conditioner_if.slave btn
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] syncFirst_q;
    logic [N_BTN-1:0] syncSecond_q;
    logic [N_BTN-1:0] level_q,   level_d;
    logic [N_BTN-1:0] press_q,   press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rptCnt_q [N_BTN];
    logic [RPT_W-1:0] rptCnt_d [N_BTN];
    logic [N_BTN-1:0] rptArmed_q, rptArmed_d;
`else
    logic unusedRepeatCfg;
    assign unusedRepeatCfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample throws the partial count away.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
`ifdef BTN_REPEAT_EN
        rptArmed_d = rptArmed_q;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (syncSecond_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]     = '0;
                level_d[i]   = ~level_q[i];
                press_d[i]   = ~level_q[i];
                release_d[i] = level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

`ifdef BTN_REPEAT_EN
            // First repeat waits REPEAT_DELAY after acceptance, later ones REPEAT_PERIOD.
            rptCnt_d[i] = rptCnt_q[i];
            if (!level_q[i] || release_d[i]) begin
                rptCnt_d[i]   = '0;
                rptArmed_d[i] = 1'b0;
            end else if (rptCnt_q[i] == (rptArmed_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                rptCnt_d[i]   = '0;
                rptArmed_d[i] = 1'b1;
                press_d[i]    = 1'b1;
            end else begin
                rptCnt_d[i] = rptCnt_q[i] + RPT_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            syncFirst_q  <= '0;
            syncSecond_q <= '0;
            level_q      <= '0;
            press_q      <= '0;
            release_q    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef BTN_REPEAT_EN
            rptArmed_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rptCnt_q[i] <= '0;
            end
`endif
        end else begin
            syncFirst_q  <= btn.btn_in;
            syncSecond_q <= syncFirst_q;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef BTN_REPEAT_EN
            rptArmed_q <= rptArmed_d;
            for (int i = 0; i < N_BTN; i++) begin
                rptCnt_q[i] <= rptCnt_d[i];
            end
`endif
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner, checked against a sample-window
// reference model plus directed timing checks from the bring-up scenarios.
module tb_button_conditioner;

    localparam int N_BTN = 4;
    localparam int DEB   = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;

    logic sysclk = 1'b0;
    logic rst;

    button_conditioner_if #(.N_BTN(N_BTN)) btnIf ();

    button_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .btn   (btnIf.slave)
    );

    always #5 sysclk = ~sysclk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference state: raw samples taken at previous edges, newest first.
    logic [N_BTN-1:0] hist [0:DEB];
    logic [N_BTN-1:0] mLevel, mPress, mRelease;
    int               mSince [N_BTN];

    task automatic checkOutput(input string tag, input logic [N_BTN-1:0] observed,
                               input logic [N_BTN-1:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %b, want %b at %0t", tag, observed, expected, $time);
    endtask

    task automatic modelReset();
        for (int j = 0; j <= DEB; j++) hist[j] = '0;
        mLevel   = '0;
        mPress   = '0;
        mRelease = '0;
        for (int ch = 0; ch < N_BTN; ch++) mSince[ch] = 0;
    endtask

    // The debouncer sees the raw value from two edges back; a level flips once
    // the last DEB such samples all disagree with it.
    task automatic modelStep();
        logic [N_BTN-1:0] inNow;
        bit allDiffer;
        inNow    = btnIf.btn_in;
        mPress   = '0;
        mRelease = '0;
        for (int ch = 0; ch < N_BTN; ch++) begin
            allDiffer = 1'b1;
            for (int j = 1; j <= DEB; j++)
                if (hist[j][ch] == mLevel[ch]) allDiffer = 1'b0;
            if (allDiffer) begin
                if (mLevel[ch]) begin
                    mRelease[ch] = 1'b1;
                    mLevel[ch]   = 1'b0;
                end else begin
                    mPress[ch]  = 1'b1;
                    mLevel[ch]  = 1'b1;
                    mSince[ch]  = 0;
                end
            end
`ifdef BTN_REPEAT_EN
            else if (mLevel[ch]) begin
                mSince[ch]++;
                if (mSince[ch] == RD || (mSince[ch] > RD && (mSince[ch] - RD) % RP == 0))
                    mPress[ch] = 1'b1;
            end
`endif
        end
        for (int j = DEB; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = inNow;
    endtask

    // One clock cycle: drive at the falling edge, step the model on the rising
    // edge, compare on the next falling edge.
    task automatic applyStimulus(input logic [N_BTN-1:0] inVal, input logic rstVal);
        btnIf.btn_in = inVal;
        rst          = rstVal;
        if (rstVal) modelReset();
        @(posedge sysclk);
        if (!rstVal) modelStep();
        @(negedge sysclk);
        checkOutput("level",   btnIf.btn_level,   mLevel);
        checkOutput("press",   btnIf.btn_press,   mPress);
        checkOutput("release", btnIf.btn_release, mRelease);
    endtask

    int pressCount;
    logic [N_BTN-1:0] randVal;
    int holdLen;

    initial begin
        rst          = 1'b1;
        btnIf.btn_in = 4'b1111;
        modelReset();
        @(negedge sysclk);

        // Held buttons through reset: silent, then one press at the sixth edge.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput("rstQuiet", btnIf.btn_level | btnIf.btn_press | btnIf.btn_release, 4'b0000);
        end
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput("rstPress", btnIf.btn_press, (c == 6) ? 4'b1111 : 4'b0000);
        end
        for (int c = 1; c <= 8; c++) applyStimulus(4'b0000, 1'b0);

        // Clean press on channel 2.
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(4'b0100, 1'b0);
            checkOutput("cleanPress", btnIf.btn_press, (c == 6) ? 4'b0100 : 4'b0000);
        end
        checkOutput("cleanLevel", btnIf.btn_level, 4'b0100);

        // Bounce on channel 0: final rise at step 6, press at step 11.
        begin
            logic [5:0] bounceSeq;
            bounceSeq = 6'b101101;
            for (int c = 1; c <= 14; c++) begin
                applyStimulus({3'b010, (c <= 6) ? bounceSeq[c-1] : 1'b1}, 1'b0);
                checkOutput("bouncePress", btnIf.btn_press & 4'b0001, (c == 11) ? 4'b0001 : 4'b0000);
            end
        end

        // Release on channel 3, then reset in the middle of a re-press.
        for (int c = 1; c <= 8; c++) applyStimulus(4'b1101, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(4'b0101, 1'b0);
            checkOutput("release3", btnIf.btn_release, (c == 6) ? 4'b1000 : 4'b0000);
        end
        for (int c = 1; c <= 3; c++) applyStimulus(4'b1101, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            applyStimulus(4'b1101, 1'b1);
            checkOutput("midRstQuiet", btnIf.btn_press | btnIf.btn_level, 4'b0000);
        end
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(4'b1101, 1'b0);
            checkOutput("postRstPress", btnIf.btn_press, (c == 6) ? 4'b1101 : 4'b0000);
        end

        // Simultaneous rise on channels 1 and 0.
        for (int c = 1; c <= 8; c++) applyStimulus(4'b0000, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(4'b0011, 1'b0);
            checkOutput("simulPress", btnIf.btn_press, (c == 6) ? 4'b0011 : 4'b0000);
        end

        // Long hold on channel 2: repeats only when the feature is built in.
        for (int c = 1; c <= 8; c++) applyStimulus(4'b0000, 1'b0);
        pressCount = 0;
        for (int c = 1; c <= 36; c++) begin
            applyStimulus(4'b0100, 1'b0);
            if (btnIf.btn_press[2]) pressCount++;
        end
`ifdef BTN_REPEAT_EN
        checkOutput("holdPresses", N_BTN'(pressCount), N_BTN'(8));
`else
        checkOutput("holdPresses", N_BTN'(pressCount), N_BTN'(1));
`endif
        pressCount = 0;
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(4'b0000, 1'b0);
            if (btnIf.btn_press[2]) pressCount++;
        end
        checkOutput("afterRelease", N_BTN'(pressCount), N_BTN'(0));

        // Random bouncing segments with occasional resets.
        for (int s = 0; s < 400; s++) begin
            randVal = N_BTN'($urandom);
            holdLen = $urandom_range(1, 9);
            if ($urandom_range(0, 40) == 0) begin
                for (int c = 0; c < $urandom_range(1, 2); c++) applyStimulus(randVal, 1'b1);
            end
            for (int c = 0; c < holdLen; c++) applyStimulus(randVal, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
